// File: rtl/tg_pulse_seq.sv
// tg_pulse_seq: timing-generator sequencer firing DA_test1..3 with programmable widths/gap and
// counting completed sequences on DA_test4. Optional macro TG_AUTO_REPEAT_EN adds tg_repeat.
module tg_pulse_seq #(
  parameter int CFG_W = 4,
  parameter int SEQ_W = 4
) (
  input  logic             clk,
  input  logic             C_purst,
  input  logic             tg_en,
  input  logic             tg_start,
`ifdef TG_AUTO_REPEAT_EN
  input  logic             tg_repeat,
`endif
  input  logic [CFG_W-1:0] B_test1,
  input  logic [CFG_W-1:0] B_test2,
  input  logic [CFG_W-1:0] B_test3,
  input  logic [CFG_W-1:0] B_test4,
  output logic             DA_test1,
  output logic             DA_test2,
  output logic             DA_test3,
  output logic [SEQ_W-1:0] DA_test4,
  output logic             tg_busy,
  output logic             tg_done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    GAP1 = 3'd2,
    PH2  = 3'd3,
    GAP2 = 3'd4,
    PH3  = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [CFG_W-1:0] CFG_ZERO = {CFG_W{1'b0}};
  localparam logic [CFG_W-1:0] CFG_ONE  = {{(CFG_W-1){1'b0}}, 1'b1};
  localparam logic [SEQ_W-1:0] SEQ_ONE  = {{(SEQ_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           next_s;
  state_t           run_next_s;
  state_t           from_start_s;
  state_t           after_ph1_s;
  state_t           after_gap1_s;
  state_t           after_ph2_s;
  state_t           after_gap2_s;

  logic [CFG_W-1:0] n1_r;
  logic [CFG_W-1:0] n2_r;
  logic [CFG_W-1:0] n3_r;
  logic [CFG_W-1:0] g_r;
  logic [CFG_W-1:0] cnt_r;
  logic [CFG_W-1:0] cnt_next_s;
  logic [CFG_W-1:0] load_s;
  logic [CFG_W-1:0] w1_s;
  logic [CFG_W-1:0] w2_s;
  logic [CFG_W-1:0] w3_s;
  logic [CFG_W-1:0] g_s;

  logic             repeat_s;
  logic             accept_s;
  logic             last_s;
  logic             enter_s;

`ifdef TG_AUTO_REPEAT_EN
  assign repeat_s = tg_repeat;
`else
  assign repeat_s = 1'b0;
`endif

  // Configuration source: live inputs where a new sequence may be accepted, latched copy otherwise.
  always_comb begin
    w1_s = n1_r;
    w2_s = n2_r;
    w3_s = n3_r;
    g_s  = g_r;
    if ((state_r == IDLE) || (state_r == DONE)) begin
      w1_s = B_test1;
      w2_s = B_test2;
      w3_s = B_test3;
      g_s  = B_test4;
    end else begin
      w1_s = n1_r;
      w2_s = n2_r;
      w3_s = n3_r;
      g_s  = g_r;
    end
  end

  // Successor chain: each phase falls through to the next one with a non-zero length.
  always_comb begin
    after_gap2_s = (w3_s != CFG_ZERO) ? PH3  : DONE;
    after_ph2_s  = (g_s  != CFG_ZERO) ? GAP2 : after_gap2_s;
    after_gap1_s = (w2_s != CFG_ZERO) ? PH2  : after_ph2_s;
    after_ph1_s  = (g_s  != CFG_ZERO) ? GAP1 : after_gap1_s;
    from_start_s = (w1_s != CFG_ZERO) ? PH1  : after_ph1_s;
  end

  // Next-state selection; dropping tg_en forces IDLE from any state.
  always_comb begin
    run_next_s = state_r;
    accept_s   = 1'b0;
    last_s     = (cnt_r == CFG_ZERO);
    case (state_r)
      IDLE: begin
        if (tg_en && tg_start) begin
          accept_s   = 1'b1;
          run_next_s = from_start_s;
        end else begin
          run_next_s = IDLE;
        end
      end
      PH1:  run_next_s = last_s ? after_ph1_s  : PH1;
      GAP1: run_next_s = last_s ? after_gap1_s : GAP1;
      PH2:  run_next_s = last_s ? after_ph2_s  : PH2;
      GAP2: run_next_s = last_s ? after_gap2_s : GAP2;
      PH3:  run_next_s = last_s ? DONE         : PH3;
      DONE: begin
        if (tg_en && repeat_s) begin
          accept_s   = 1'b1;
          run_next_s = from_start_s;
        end else begin
          run_next_s = IDLE;
        end
      end
      default: run_next_s = IDLE;
    endcase
    next_s = tg_en ? run_next_s : IDLE;
  end

  // Phase down-counter: loads length-1 on phase entry, terminal count is zero.
  always_comb begin
    enter_s = (next_s != state_r) || accept_s;
    case (next_s)
      PH1:     load_s = w1_s - CFG_ONE;
      GAP1:    load_s = g_s  - CFG_ONE;
      PH2:     load_s = w2_s - CFG_ONE;
      GAP2:    load_s = g_s  - CFG_ONE;
      PH3:     load_s = w3_s - CFG_ONE;
      default: load_s = CFG_ZERO;
    endcase
    if (enter_s) begin
      cnt_next_s = load_s;
    end else if (cnt_r != CFG_ZERO) begin
      cnt_next_s = cnt_r - CFG_ONE;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // State, counter and latched configuration.
  always_ff @(posedge clk or posedge C_purst) begin
    if (C_purst) begin
      state_r <= IDLE;
      cnt_r   <= CFG_ZERO;
      n1_r    <= CFG_ZERO;
      n2_r    <= CFG_ZERO;
      n3_r    <= CFG_ZERO;
      g_r     <= CFG_ZERO;
    end else begin
      state_r <= next_s;
      cnt_r   <= cnt_next_s;
      if (accept_s) begin
        n1_r <= B_test1;
        n2_r <= B_test2;
        n3_r <= B_test3;
        g_r  <= B_test4;
      end
    end
  end

  // Registered outputs decoded from the next state so they align with the state register.
  always_ff @(posedge clk or posedge C_purst) begin
    if (C_purst) begin
      DA_test1 <= 1'b0;
      DA_test2 <= 1'b0;
      DA_test3 <= 1'b0;
      DA_test4 <= {SEQ_W{1'b0}};
      tg_busy  <= 1'b0;
      tg_done  <= 1'b0;
    end else begin
      DA_test1 <= (next_s == PH1);
      DA_test2 <= (next_s == PH2);
      DA_test3 <= (next_s == PH3);
      tg_busy  <= (next_s != IDLE);
      tg_done  <= (next_s == DONE);
      if ((next_s == DONE) && enter_s) begin
        DA_test4 <= DA_test4 + SEQ_ONE;
      end
    end
  end

endmodule

// File: tb/tb_tg_pulse_seq.sv
// Scoreboard bench for tg_pulse_seq: per-cycle expected output vectors are queued when a
// sequence is launched and compared at each falling edge.
module tb_tg_pulse_seq;
  localparam int CFG_W = 4;
  localparam int SEQ_W = 4;

  logic             clk = 1'b0;
  logic             C_purst;
  logic             tg_en;
  logic             tg_start;
`ifdef TG_AUTO_REPEAT_EN
  logic             tg_repeat;
`endif
  logic [CFG_W-1:0] B_test1, B_test2, B_test3, B_test4;
  logic             DA_test1, DA_test2, DA_test3;
  logic [SEQ_W-1:0] DA_test4;
  logic             tg_busy, tg_done;

  tg_pulse_seq #(.CFG_W(CFG_W), .SEQ_W(SEQ_W)) dut (
    .clk      (clk),
    .C_purst  (C_purst),
    .tg_en    (tg_en),
    .tg_start (tg_start),
`ifdef TG_AUTO_REPEAT_EN
    .tg_repeat(tg_repeat),
`endif
    .B_test1  (B_test1),
    .B_test2  (B_test2),
    .B_test3  (B_test3),
    .B_test4  (B_test4),
    .DA_test1 (DA_test1),
    .DA_test2 (DA_test2),
    .DA_test3 (DA_test3),
    .DA_test4 (DA_test4),
    .tg_busy  (tg_busy),
    .tg_done  (tg_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             d1;
    logic             d2;
    logic             d3;
    logic [SEQ_W-1:0] d4;
    logic             busy;
    logic             done;
  } vec_t;

  vec_t             exp_q[$];
  logic [SEQ_W-1:0] exp_cnt;
  int               vectors_applied = 0;
  int               miscompares = 0;

  task automatic check_value(input string tag, input vec_t got, input vec_t exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got d1d2d3=%b%b%b cnt=%0d busy=%b done=%b, expected d1d2d3=%b%b%b cnt=%0d busy=%b done=%b",
               tag, got.d1, got.d2, got.d3, got.d4, got.busy, got.done,
               exp.d1, exp.d2, exp.d3, exp.d4, exp.busy, exp.done);
    end
  endtask

  function automatic vec_t mk(input logic d1, input logic d2, input logic d3,
                              input logic busy, input logic done, input logic [SEQ_W-1:0] c);
    vec_t v;
    v.d1 = d1; v.d2 = d2; v.d3 = d3; v.d4 = c; v.busy = busy; v.done = done;
    return v;
  endfunction

  function automatic vec_t sample();
    return mk(DA_test1, DA_test2, DA_test3, tg_busy, tg_done, DA_test4);
  endfunction

  // Reference timeline of one sequence: N1 high, G gap, N2 high, G gap, N3 high, one DONE cycle.
  task automatic push_seq(input int n1, input int n2, input int n3, input int g, input bit add_idle);
    for (int i = 0; i < n1; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, exp_cnt));
    for (int i = 0; i < g;  i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp_cnt));
    for (int i = 0; i < n2; i++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, exp_cnt));
    for (int i = 0; i < g;  i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp_cnt));
    for (int i = 0; i < n3; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, exp_cnt));
    exp_cnt = exp_cnt + 4'd1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, exp_cnt));
    if (add_idle) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt));
  endtask

  task automatic launch(input int n1, input int n2, input int n3, input int g);
    B_test1  = 4'(n1);
    B_test2  = 4'(n2);
    B_test3  = 4'(n3);
    B_test4  = 4'(g);
    tg_start = 1'b1;
  endtask

  // Pops up to max_pops entries, one per cycle; hook 1 rewrites B_test2, hook 2 clears tg_repeat.
  task automatic drain(input string tag, input int max_pops, input int hook_at,
                       input int hook_id, input bit keep_start);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < max_pops) begin
      @(negedge clk);
      check_value(tag, sample(), exp_q.pop_front());
      if (k == 0 && !keep_start) tg_start = 1'b0;
      if (k == hook_at) begin
        case (hook_id)
          1: B_test2 = 4'd9;
`ifdef TG_AUTO_REPEAT_EN
          2: tg_repeat = 1'b0;
`endif
          default: ;
        endcase
      end
      k++;
    end
  endtask

  logic [SEQ_W-1:0] saved_cnt;

  initial begin
    C_purst = 1'b1; tg_en = 1'b1; tg_start = 1'b0;
    B_test1 = 4'd0; B_test2 = 4'd0; B_test3 = 4'd0; B_test4 = 4'd0;
`ifdef TG_AUTO_REPEAT_EN
    tg_repeat = 1'b0;
`endif
    exp_cnt = 4'd0;

    @(negedge clk);
    check_value("reset", sample(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    @(negedge clk);
    C_purst = 1'b0;

    // tg_en low in IDLE blocks the start
    tg_en = 1'b0;
    launch(1, 1, 1, 1);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    drain("en_block", 100, -1, 0, 1'b1);
    tg_start = 1'b0;
    tg_en = 1'b1;

    launch(3, 2, 5, 1);
    push_seq(3, 2, 5, 1, 1'b1);
    drain("widths", 100, -1, 0, 1'b0);

    launch(0, 4, 0, 0);
    push_seq(0, 4, 0, 0, 1'b1);
    drain("zero_skip", 100, -1, 0, 1'b0);

    launch(0, 0, 0, 0);
    push_seq(0, 0, 0, 0, 1'b1);
    drain("all_zero", 100, -1, 0, 1'b0);

    launch(2, 0, 1, 2);
    push_seq(2, 0, 1, 2, 1'b1);
    drain("gap_skip_pulse", 100, -1, 0, 1'b0);

    // config change mid-run ignored; held start restarts only after one IDLE cycle
    launch(3, 2, 1, 1);
    push_seq(3, 2, 1, 1, 1'b1);
    drain("cfg_latch", 100, 0, 1, 1'b1);
    push_seq(3, 9, 1, 1, 1'b1);
    drain("cfg_second", 100, -1, 0, 1'b0);

    // async reset during PH2
    launch(1, 4, 1, 1);
    push_seq(1, 4, 1, 1, 1'b0);
    drain("rst_pre", 3, -1, 0, 1'b0);
    C_purst = 1'b1;
    #1;
    check_value("rst_async", sample(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    exp_q.delete();
    exp_cnt = 4'd0;
    @(negedge clk);
    check_value("rst_hold", sample(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    C_purst = 1'b0;

    // tg_en abort during PH2
    launch(1, 1, 1, 1);
    push_seq(1, 1, 1, 1, 1'b1);
    drain("pre_abort", 100, -1, 0, 1'b0);
    saved_cnt = exp_cnt;
    launch(1, 4, 1, 1);
    push_seq(1, 4, 1, 1, 1'b0);
    drain("abort_pre", 3, -1, 0, 1'b0);
    tg_en = 1'b0;
    #1;
    check_value("abort_sync", sample(), mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, saved_cnt));
    exp_q.delete();
    exp_cnt = saved_cnt;
    @(negedge clk);
    check_value("abort", sample(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, saved_cnt));
    @(negedge clk);
    check_value("abort_idle", sample(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, saved_cnt));
    tg_en = 1'b1;

    // sequence counter wrap: reset to zero, then 16 runs
    C_purst = 1'b1;
    @(negedge clk);
    C_purst = 1'b0;
    exp_cnt = 4'd0;
    for (int s = 0; s < 16; s++) begin
      launch(1, 1, 1, 1);
      push_seq(1, 1, 1, 1, 1'b1);
      drain("wrap", 100, -1, 0, 1'b0);
    end

`ifdef TG_AUTO_REPEAT_EN
    tg_repeat = 1'b1;
    launch(2, 1, 1, 1);
    push_seq(2, 1, 1, 1, 1'b0);
    push_seq(2, 1, 1, 1, 1'b1);
    drain("repeat", 100, 7, 2, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
